// File: rtl/pmo_event_sched_pkg.sv
// Shared definitions for the PMO event scheduler and the screen controller.
//   - EV_* event codes carried on ev_code
//   - SRC_* indices into the pending/edge bit vectors (also the priority order,
//     lowest index = highest priority)
//   - FSM state type
//   - helpers mapping between source index, event code and one-hot vectors
package pmo_event_sched_pkg;

   localparam int unsigned NSRC = 11;

   localparam int unsigned SRC_GO     = 0;
   localparam int unsigned SRC_WAKE   = 1;
   localparam int unsigned SRC_TOUCH  = 2;
   localparam int unsigned SRC_PET    = 3;
   localparam int unsigned SRC_EXPECT = 4;
   localparam int unsigned SRC_PRESS  = 5;
   localparam int unsigned SRC_UP     = 6;
   localparam int unsigned SRC_DOWN   = 7;
   localparam int unsigned SRC_LEFT   = 8;
   localparam int unsigned SRC_RIGHT  = 9;
   localparam int unsigned SRC_SLEEP  = 10;

   localparam logic [3:0] EV_NONE   = 4'd0;
   localparam logic [3:0] EV_WAKE   = 4'd1;
   localparam logic [3:0] EV_TOUCH  = 4'd2;
   localparam logic [3:0] EV_PET    = 4'd3;
   localparam logic [3:0] EV_EXPECT = 4'd4;
   localparam logic [3:0] EV_PRESS  = 4'd5;
   localparam logic [3:0] EV_UP     = 4'd6;
   localparam logic [3:0] EV_DOWN   = 4'd7;
   localparam logic [3:0] EV_LEFT   = 4'd8;
   localparam logic [3:0] EV_RIGHT  = 4'd9;
   localparam logic [3:0] EV_SLEEP  = 4'd10;
   localparam logic [3:0] EV_GO     = 4'd11;

   // Sources still eligible while the pet sleeps: GO, WAKE, TOUCH, PRESS.
   localparam logic [NSRC-1:0] SLEEP_MASK = 11'b000_0010_0111;

   typedef enum logic [1:0] {
      S_IDLE,
      S_OFFER,
      S_COOL
   } state_e;

   // Source index -> event code (codes equal the index except GO).
   function automatic logic [3:0] src_code(input int unsigned idx);
      return (idx == SRC_GO) ? EV_GO : 4'(idx);
   endfunction

   // Highest-priority set bit -> event code; EV_NONE when nothing is set.
   function automatic logic [3:0] pick_code(input logic [NSRC-1:0] elig);
      logic [3:0] code;
      code = EV_NONE;
      for (int unsigned i = 0; i < NSRC; i++) begin
         if (elig[NSRC-1-i]) code = src_code(NSRC-1-i);
      end
      return code;
   endfunction

   // Event code -> one-hot source vector (all zero for EV_NONE/unknown codes).
   function automatic logic [NSRC-1:0] code_onehot(input logic [3:0] code);
      logic [NSRC-1:0] oh;
      oh = '0;
      for (int unsigned i = 0; i < NSRC; i++) begin
         oh[i] = (src_code(i) == code);
      end
      return oh;
   endfunction

endpackage

// File: rtl/pmo_event_sched_tick_gen.sv
// Millisecond prescaler: counts 0..TICK_CYC-1 and pulses tick_o for one
// cycle on the terminal count.
//   clk_i   system clock
//   rst_i   asynchronous active-high reset
//   tick_o  one-cycle pulse every TICK_CYC cycles
module pmo_tick_gen #(
   parameter int unsigned TICK_CYC = 100_000
) (
   input  logic clk_i,
   input  logic rst_i,
   output logic tick_o
);

   localparam int unsigned W = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;

   logic [W-1:0] cnt_q, cnt_d;
   logic         wrap;

   always_comb begin
      wrap  = (cnt_q == W'(TICK_CYC - 1));
      cnt_d = wrap ? '0 : cnt_q + W'(1);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign tick_o = wrap;

endmodule

// File: rtl/pmo_event_sched.sv
// Event scheduler between the PMO sensor blocks and the screen controller.
// Turns level sensor flags into single events, arbitrates them by fixed
// priority, offers one at a time over valid/ready, enforces a cooldown after
// each accepted event and raises SLEEP after a period of inactivity.
//   clk, rst             clock, asynchronous active-high reset
//   go                   one-cycle go pulse
//   awaking..right       level sensor/joystick flags
//   ev_valid/ev_ready    event handshake to the screen controller
//   ev_code              event code, valid while ev_valid=1
//   busy                 FSM not idle
//   sleeping             pet is asleep
module pmo_event_sched
   import pmo_event_sched_pkg::*;
#(
   parameter int unsigned TICK_CYC     = 100_000,
   parameter int unsigned COOLDOWN_CYC = 20_000_000,
   parameter int unsigned IDLE_MS      = 30_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       go,
   input  logic       awaking,
   input  logic       touched,
   input  logic       petting,
   input  logic       expecting,
   input  logic       pressed,
   input  logic       up,
   input  logic       down,
   input  logic       left,
   input  logic       right,
   output logic       ev_valid,
   input  logic       ev_ready,
   output logic [3:0] ev_code,
   output logic       busy,
   output logic       sleeping
);

   localparam int unsigned CW = (COOLDOWN_CYC > 1) ? $clog2(COOLDOWN_CYC + 1) : 1;

   state_e          state_q, state_d;
   logic            ev_valid_q, ev_valid_d;
   logic [3:0]      ev_code_q, ev_code_d;
   logic [CW-1:0]   cool_q, cool_d;
   logic [15:0]     idle_q, idle_d;
   logic            sleep_q, sleep_d;
   logic            arm_q;
   logic [NSRC-1:0] prev_q, pend_q, pend_d;
   logic [NSRC-1:0] lvl, rise, set, clr, elig, xfer_oh;
   logic            xfer, tick, sleep_raise;

   pmo_tick_gen #(.TICK_CYC(TICK_CYC)) u_tick (
      .clk_i  (clk),
      .rst_i  (rst),
      .tick_o (tick)
   );

   // GO and SLEEP have no level input; their slots stay zero here.
   assign lvl  = {1'b0, right, left, down, up, pressed, expecting, petting,
                  touched, awaking, 1'b0};
   assign xfer = ev_valid_q & ev_ready;
   assign xfer_oh = code_onehot(ev_code_q);

   // Edges are ignored until prev has sampled the inputs once after reset, so
   // levels already high at reset release produce no event until they toggle.
   assign rise = lvl & ~prev_q & {NSRC{arm_q}};

   // Idle counter: cleared by any non-SLEEP transfer, saturates at IDLE_MS and
   // raises SLEEP once on reaching it.
   always_comb begin
      idle_d      = idle_q;
      sleep_raise = 1'b0;
      if (xfer && ev_code_q != EV_SLEEP) begin
         idle_d = '0;
      end else if (tick && idle_q != 16'(IDLE_MS)) begin
         idle_d      = idle_q + 16'd1;
         sleep_raise = (idle_d == 16'(IDLE_MS)) && !sleep_q;
      end
   end

   // Pending bank: set wins over clear when an edge lands in the transfer cycle.
   always_comb begin
      set = rise;
      set[SRC_GO]    = go;
      set[SRC_SLEEP] = sleep_raise;
      clr    = xfer ? xfer_oh : '0;
      pend_d = (pend_q & ~clr) | set;
      if (sleep_q) pend_d = pend_d & SLEEP_MASK;
      elig = sleep_q ? (pend_q & SLEEP_MASK) : pend_q;
   end

   always_comb begin
      sleep_d = sleep_q;
      if (xfer) begin
         if (ev_code_q == EV_SLEEP)              sleep_d = 1'b1;
         else if ((xfer_oh & SLEEP_MASK) != '0)  sleep_d = 1'b0;
      end
   end

   always_comb begin
      state_d    = state_q;
      ev_valid_d = ev_valid_q;
      ev_code_d  = ev_code_q;
      cool_d     = cool_q;
      case (state_q)
         S_IDLE: begin
            if (elig != '0) begin
               ev_valid_d = 1'b1;
               ev_code_d  = pick_code(elig);
               state_d    = S_OFFER;
            end
         end
         S_OFFER: begin
            if (ev_ready) begin
               ev_valid_d = 1'b0;
               cool_d     = '0;
               state_d    = S_COOL;
            end
         end
         S_COOL: begin
            if (cool_q == CW'(COOLDOWN_CYC - 1)) state_d = S_IDLE;
            else                                 cool_d  = cool_q + CW'(1);
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         ev_valid_q <= 1'b0;
         ev_code_q  <= EV_NONE;
         cool_q     <= '0;
         idle_q     <= '0;
         sleep_q    <= 1'b0;
         arm_q      <= 1'b0;
         prev_q     <= '0;
         pend_q     <= '0;
      end else begin
         state_q    <= state_d;
         ev_valid_q <= ev_valid_d;
         ev_code_q  <= ev_code_d;
         cool_q     <= cool_d;
         idle_q     <= idle_d;
         sleep_q    <= sleep_d;
         arm_q      <= 1'b1;
         prev_q     <= lvl;
         pend_q     <= pend_d;
      end
   end

   assign ev_valid = ev_valid_q;
   assign ev_code  = ev_code_q;
   assign busy     = (state_q != S_IDLE);
   assign sleeping = sleep_q;

endmodule

// File: tb/tb_pmo_event_sched.sv
module tb_pmo_event_sched;

   logic       clk = 1'b0;
   logic       rst;
   logic       go, awaking, touched, petting, expecting, pressed;
   logic       up, down, left, right;
   logic       ev_valid, ev_ready, busy, sleeping;
   logic [3:0] ev_code;

   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   int         last_xfer = 0;
   logic [3:0] exp_q[$];
   logic [3:0] exp_code;

   pmo_event_sched #(
      .TICK_CYC     (10),
      .COOLDOWN_CYC (20),
      .IDLE_MS      (50)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .go        (go),
      .awaking   (awaking),
      .touched   (touched),
      .petting   (petting),
      .expecting (expecting),
      .pressed   (pressed),
      .up        (up),
      .down      (down),
      .left      (left),
      .right     (right),
      .ev_valid  (ev_valid),
      .ev_ready  (ev_ready),
      .ev_code   (ev_code),
      .busy      (busy),
      .sleeping  (sleeping)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard: every accepted event is checked against the expected queue.
   always @(negedge clk) begin
      if (!rst && ev_valid && ev_ready) begin
         if (ev_code != 4'd10) last_xfer = cyc + 1;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: transferred code %0d, no event expected", ev_code);
         end else begin
            exp_code = exp_q.pop_front();
            if (ev_code !== exp_code) begin
               errors++;
               $display("FAIL sb_code: transferred code %0d, expected %0d", ev_code, exp_code);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(input int maxc, output int n);
      n = 0;
      while (ev_valid !== 1'b1 && n < maxc) begin
         step();
         n++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; go = 0; awaking = 0; touched = 0; petting = 0; expecting = 0;
      pressed = 0; up = 0; down = 0; left = 0; right = 0; ev_ready = 1'b0;
      repeat (3) step();
      checks++;
      if ({ev_valid, busy, sleeping, ev_code} !== 7'b0) begin
         errors++;
         $display("FAIL reset_outputs: valid=%b busy=%b sleeping=%b code=%0d, want all 0",
                  ev_valid, busy, sleeping, ev_code);
      end
      rst = 1'b0;
      repeat (5) step();
   endtask

   task automatic test_single();
      int hits;
      ev_ready = 1'b1;
      touched  = 1'b1;
      exp_q.push_back(4'd2);
      step();
      checks++;
      if (ev_valid !== 1'b0) begin
         errors++; $display("FAIL t1_early: valid=%b, want 0 one cycle after edge", ev_valid);
      end
      step();
      checks++;
      if (ev_valid !== 1'b1 || ev_code !== 4'd2) begin
         errors++; $display("FAIL t1_offer: valid=%b code=%0d, want valid=1 code=2", ev_valid, ev_code);
      end
      step();
      checks++;
      if (ev_valid !== 1'b0 || busy !== 1'b1) begin
         errors++; $display("FAIL t1_drop: valid=%b busy=%b, want valid=0 busy=1", ev_valid, busy);
      end
      repeat (19) step();
      checks++;
      if (busy !== 1'b1) begin
         errors++; $display("FAIL t1_cool_last: busy=%b, want 1", busy);
      end
      step();
      checks++;
      if (busy !== 1'b0) begin
         errors++; $display("FAIL t1_cool_end: busy=%b, want 0", busy);
      end
      hits = 0;
      repeat (30) begin
         step();
         if (ev_valid === 1'b1) hits++;
      end
      checks++;
      if (hits != 0) begin
         errors++; $display("FAIL t1_held: %0d valid cycles while level held, want 0", hits);
      end
      touched = 1'b0;
      step();
   endtask

   task automatic test_priority();
      int n;
      ev_ready = 1'b0;
      up       = 1'b1;
      awaking  = 1'b1;
      exp_q.push_back(4'd1);
      exp_q.push_back(4'd6);
      step();
      step();
      checks++;
      if (ev_valid !== 1'b1 || ev_code !== 4'd1) begin
         errors++; $display("FAIL t2_first: valid=%b code=%0d, want valid=1 code=1", ev_valid, ev_code);
      end
      repeat (4) begin
         step();
         checks++;
         if (ev_valid !== 1'b1 || ev_code !== 4'd1) begin
            errors++; $display("FAIL t2_hold: valid=%b code=%0d, want valid=1 code=1", ev_valid, ev_code);
         end
      end
      ev_ready = 1'b1;
      step();
      wait_valid(40, n);
      checks++;
      if (n != 21 || ev_code !== 4'd6) begin
         errors++; $display("FAIL t2_second: wait=%0d code=%0d, want wait=21 code=6", n, ev_code);
      end
      step();
      repeat (21) step();
      up = 1'b0; awaking = 1'b0;
      step();
   endtask

   task automatic test_go_no_preempt();
      int n;
      ev_ready  = 1'b0;
      expecting = 1'b1;
      exp_q.push_back(4'd4);
      step();
      step();
      checks++;
      if (ev_valid !== 1'b1 || ev_code !== 4'd4) begin
         errors++; $display("FAIL t4_offer: valid=%b code=%0d, want valid=1 code=4", ev_valid, ev_code);
      end
      go = 1'b1;
      exp_q.push_back(4'd11);
      step();
      go = 1'b0;
      step();
      step();
      checks++;
      if (ev_valid !== 1'b1 || ev_code !== 4'd4) begin
         errors++; $display("FAIL t4_no_preempt: valid=%b code=%0d, want valid=1 code=4", ev_valid, ev_code);
      end
      ev_ready = 1'b1;
      step();
      wait_valid(40, n);
      checks++;
      if (n != 21 || ev_code !== 4'd11) begin
         errors++; $display("FAIL t4_go: wait=%0d code=%0d, want wait=21 code=11", n, ev_code);
      end
      step();
      repeat (21) step();
      expecting = 1'b0;
      step();
   endtask

   task automatic test_same_source();
      int n;
      ev_ready = 1'b0;
      touched  = 1'b1;
      exp_q.push_back(4'd2);
      step();
      step();
      checks++;
      if (ev_valid !== 1'b1 || ev_code !== 4'd2) begin
         errors++; $display("FAIL t6_offer: valid=%b code=%0d, want valid=1 code=2", ev_valid, ev_code);
      end
      touched = 1'b0;
      step();
      touched  = 1'b1;
      ev_ready = 1'b1;
      exp_q.push_back(4'd2);
      step();
      wait_valid(40, n);
      checks++;
      if (n != 21 || ev_code !== 4'd2) begin
         errors++; $display("FAIL t6_reoffer: wait=%0d code=%0d, want wait=21 code=2", n, ev_code);
      end
      step();
      repeat (21) step();
      touched = 1'b0;
      step();
   endtask

   task automatic test_sleep();
      int n, hits, elapsed;
      ev_ready = 1'b1;
      exp_q.push_back(4'd10);
      wait_valid(700, n);
      // 50 ticks of 10 cycles after the last transfer, tick phase unknown,
      // plus one cycle to offer: 492..501 cycles.
      elapsed = cyc - last_xfer;
      checks++;
      if (ev_valid !== 1'b1 || ev_code !== 4'd10 || elapsed < 492 || elapsed > 501) begin
         errors++; $display("FAIL t3_sleep_offer: valid=%b code=%0d elapsed=%0d, want valid=1 code=10 elapsed 492..501",
                            ev_valid, ev_code, elapsed);
      end
      step();
      checks++;
      if (sleeping !== 1'b1) begin
         errors++; $display("FAIL t3_asleep: sleeping=%b, want 1", sleeping);
      end
      repeat (21) step();
      left = 1'b1;
      hits = 0;
      repeat (30) begin
         step();
         if (ev_valid === 1'b1) hits++;
      end
      checks++;
      if (hits != 0) begin
         errors++; $display("FAIL t3_left_masked: %0d valid cycles while asleep, want 0", hits);
      end
      left    = 1'b0;
      step();
      pressed = 1'b1;
      exp_q.push_back(4'd5);
      step();
      step();
      checks++;
      if (ev_valid !== 1'b1 || ev_code !== 4'd5 || sleeping !== 1'b1) begin
         errors++; $display("FAIL t3_press: valid=%b code=%0d sleeping=%b, want 1 5 1", ev_valid, ev_code, sleeping);
      end
      step();
      checks++;
      if (sleeping !== 1'b0) begin
         errors++; $display("FAIL t3_wake: sleeping=%b, want 0", sleeping);
      end
      pressed = 1'b0;
      repeat (22) step();
   endtask

   task automatic test_reset_mid();
      int hits;
      ev_ready = 1'b0;
      petting  = 1'b1;
      step();
      step();
      checks++;
      if (ev_valid !== 1'b1 || ev_code !== 4'd3) begin
         errors++; $display("FAIL t5_offer: valid=%b code=%0d, want valid=1 code=3", ev_valid, ev_code);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (ev_valid !== 1'b0 || busy !== 1'b0 || ev_code !== 4'd0) begin
         errors++; $display("FAIL t5_async: valid=%b busy=%b code=%0d, want 0 0 0", ev_valid, busy, ev_code);
      end
      step();
      rst      = 1'b0;
      ev_ready = 1'b1;
      hits = 0;
      repeat (30) begin
         step();
         if (ev_valid === 1'b1) hits++;
      end
      checks++;
      if (hits != 0) begin
         errors++; $display("FAIL t5_held: %0d valid cycles after reset with level held, want 0", hits);
      end
      petting = 1'b0;
      step();
      petting = 1'b1;
      exp_q.push_back(4'd3);
      step();
      step();
      checks++;
      if (ev_valid !== 1'b1 || ev_code !== 4'd3) begin
         errors++; $display("FAIL t5_toggle: valid=%b code=%0d, want valid=1 code=3", ev_valid, ev_code);
      end
      step();
      repeat (21) step();
      petting = 1'b0;
      step();
   endtask

   initial begin
      test_reset();
      test_single();
      test_priority();
      test_go_no_preempt();
      test_same_source();
      test_sleep();
      test_reset_mid();
      checks++;
      if (exp_q.size() != 0) begin
         errors++; $display("FAIL sb_leftover: %0d expected events never transferred, want 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
